// File: rtl/scan_controller_if.sv
// Word-stream bundle between the debug/test access logic and scan_controller:
// chain image words in, captured chain words out, each with valid/ready.
interface scan_controller_if;
  logic [15:0] InData;
  logic        InValid;
  logic        InReady;
  logic [15:0] OutData;
  logic        OutValid;
  logic        OutReady;

  modport master (
    output InData, InValid, OutReady,
    input  InReady, OutData, OutValid
  );

  modport slave (
    input  InData, InValid, OutReady,
    output InReady, OutData, OutValid
  );
endinterface

// File: rtl/scan_controller.sv
// Scan-chain host: loads a chain image as 16-bit words, shifts it through Test/SDI
// in one unbroken burst, and returns the SDO capture as words (macro SCAN_CAPTURE_EN).
module scan_controller #(
  parameter int CHAIN_LEN = 128
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Test,
  output logic              SDI,
  input  logic              SDO,
  scan_controller_if.slave  bus
);
  localparam int WORDS  = CHAIN_LEN / 16;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int BCNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UNLOAD, FIN} state_e;

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     word_q, word_d;
  logic [BCNT_W-1:0]     bit_q, bit_d;
  logic [CHAIN_LEN-1:0]  buf_q, buf_d;
  logic                  busy_q, busy_d, done_q, done_d, test_q, test_d, sdi_q, sdi_d;
  logic                  inready_q, inready_d, outvalid_q, outvalid_d;
  logic [15:0]           outdata_q, outdata_d;
  logic                  sdo_bit;

`ifdef SCAN_CAPTURE_EN
  assign sdo_bit = SDO;
`else
  logic unused_inputs;
  assign unused_inputs = SDO ^ bus.OutReady;
  assign sdo_bit       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = LOAD;
        word_d  = '0;
        bit_d   = '0;
      end
      LOAD: if (bus.InValid && inready_q) begin
        buf_d  = {bus.InData, buf_q[CHAIN_LEN-1:16]};
        word_d = word_q + 1'b1;
        if (word_q == WORD_LAST) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        buf_d = {sdo_bit, buf_q[CHAIN_LEN-1:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d  = '0;
          word_d = '0;
`ifdef SCAN_CAPTURE_EN
          state_d = UNLOAD;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef SCAN_CAPTURE_EN
      UNLOAD: if (outvalid_q && bus.OutReady) begin
        buf_d  = buf_q >> 16;
        word_d = word_q + 1'b1;
        if (word_q == WORD_LAST) state_d = FIN;
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so none is combinational from inputs
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
    test_d    = (state_d == SHIFT);
    sdi_d     = (state_d == SHIFT) && buf_d[0];
    inready_d = (state_d == LOAD);
`ifdef SCAN_CAPTURE_EN
    outvalid_d = (state_d == UNLOAD);
`else
    outvalid_d = 1'b0;
`endif
    outdata_d = outvalid_d ? buf_d[15:0] : 16'h0000;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      test_q     <= 1'b0;
      sdi_q      <= 1'b0;
      inready_q  <= 1'b0;
      outvalid_q <= 1'b0;
      outdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      test_q     <= test_d;
      sdi_q      <= sdi_d;
      inready_q  <= inready_d;
      outvalid_q <= outvalid_d;
      outdata_q  <= outdata_d;
    end
  end

  // Chain image is pure data and carries no reset
  always_ff @(posedge Clock) begin
    buf_q <= buf_d;
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Test         = test_q;
  assign SDI          = sdi_q;
  assign bus.InReady  = inready_q;
  assign bus.OutValid = outvalid_q;
  assign bus.OutData  = outdata_q;
endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller with a 128-bit model of the scan chain;
// covers the capture build when SCAN_CAPTURE_EN is defined, else the load-only build.
module tb_scan_controller;
  localparam int CHAIN_LEN = 128;
  localparam int WORDS     = CHAIN_LEN / 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, test, sdi, sdo;
  logic preload = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] exp_chain;
  logic [15:0] load_w [WORDS];
  logic [15:0] exp_out [WORDS];
  int n_checks = 0;
  int n_fail   = 0;
  int test_cnt = 0, done_cnt = 0, ov_cnt = 0;
  int t0, d0, gap_hi;

  scan_controller_if bus();

  scan_controller #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .Clock (clk),
    .Reset (rst),
    .Start (start),
    .Busy  (busy),
    .Done  (done),
    .Test  (test),
    .SDI   (sdi),
    .SDO   (sdo),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Chain model: SDI enters at the head, SDO leaves from the tail
  assign sdo = chain[0];
  always @(posedge clk) begin
    if (preload)   chain <= preload_val;
    else if (test) chain <= {sdi, chain[CHAIN_LEN-1:1]};
  end

  always @(negedge clk) begin
    if (test)         test_cnt <= test_cnt + 1;
    if (done)         done_cnt <= done_cnt + 1;
    if (bus.OutValid) ov_cnt   <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op();
    t0 = test_cnt;
    d0 = done_cnt;
    for (int i = 0; i < WORDS; i++) exp_chain[16*i +: 16] = load_w[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("inready_after_start", bus.InReady, 1'b1);
  endtask

  task automatic load_words(input int gap);
    int n;
    gap_hi = 0;
    for (int i = 0; i < WORDS; i++) begin
      bus.InData  = load_w[i];
      bus.InValid = 1'b1;
      n = 0;
      while (!bus.InReady && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.InReady) check("inready_wait", bus.InReady, 1'b1);
      @(negedge clk);
      bus.InValid = 1'b0;
      bus.InData  = 16'h0000;
      if (i < WORDS - 1) begin
        repeat (gap) begin
          if (test) gap_hi++;
          @(negedge clk);
        end
      end
    end
    check("test_first_shift", test, 1'b1);
    check("inready_in_shift", bus.InReady, 1'b0);
  endtask

  task automatic finish_op(input int stall_word, input int stall_len);
    int n;
    repeat (CHAIN_LEN - 1) @(negedge clk);
    check("test_last_shift", test, 1'b1);
    @(negedge clk);
    check("test_after_shift", test, 1'b0);
`ifdef SCAN_CAPTURE_EN
    check("outvalid_first", bus.OutValid, 1'b1);
    for (int i = 0; i < WORDS; i++) begin
      n = 0;
      while (!bus.OutValid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.OutValid) check("outvalid_wait", bus.OutValid, 1'b1);
      if (i == stall_word) begin
        repeat (stall_len) begin
          check("stall_data", bus.OutData, exp_out[i]);
          check("stall_test", test, 1'b0);
          @(negedge clk);
        end
      end
      check($sformatf("out_word%0d", i), bus.OutData, exp_out[i]);
      bus.OutReady = 1'b1;
      @(negedge clk);
      bus.OutReady = 1'b0;
    end
`endif
    check("done_pulse", done, 1'b1);
    check("busy_in_fin", busy, 1'b1);
    check("outvalid_in_fin", bus.OutValid, 1'b0);
    @(negedge clk);
    check("done_after", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("test_high_count", test_cnt - t0, CHAIN_LEN);
    check("done_count", done_cnt - d0, 1);
    check("chain_image", chain, exp_chain);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hi, test_hi, misc_hi;
    bus.InData   = 16'h0000;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_test", test, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_inready", bus.InReady, 1'b0);
    check("rst_outvalid", bus.OutValid, 1'b0);
    check("rst_outdata", bus.OutData, 16'h0000);
    rst = 1'b0;

    // Idle with Start low
    busy_hi = 0; test_hi = 0; misc_hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) busy_hi++;
      if (test) test_hi++;
      if (done || bus.InReady || bus.OutValid || sdi) misc_hi++;
    end
    check("idle_busy", busy_hi, 0);
    check("idle_test", test_hi, 0);
    check("idle_other", misc_hi, 0);

    // Preloaded chain, load 0x0001..0x0008
    for (int i = 0; i < WORDS; i++) preload_val[16*i +: 16] = 16'hA5A5;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      load_w[i]  = 16'(i + 1);
      exp_out[i] = 16'hA5A5;
    end
    start_op();
    load_words(0);
    finish_op(-1, 0);

    // Same image with input gaps and output stall on word 2
    for (int i = 0; i < WORDS; i++) exp_out[i] = 16'(i + 1);
    start_op();
    load_words(3);
    check("gap_test_low", gap_hi, 0);
    finish_op(2, 5);

    // Round trip: zeros in, previous image out in order
    for (int i = 0; i < WORDS; i++) load_w[i] = 16'h0000;
    start_op();
    load_words(0);
    finish_op(-1, 0);

    // Start during SHIFT ignored, then reset at shift cycle 40
    for (int i = 0; i < WORDS; i++) load_w[i] = 16'hC3C3 ^ 16'(i);
    start_op();
    load_words(0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_shift_test", test, 1'b1);
    check("start_in_shift_inready", bus.InReady, 1'b0);
    repeat (29) @(negedge clk);
    check("pre_reset_test", test, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_test", test, 1'b0);
    check("async_rst_sdi", sdi, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_test", test, 1'b0);

    // Full operation after the abandoned one
    for (int i = 0; i < WORDS; i++) begin
      load_w[i]  = 16'h1000 + 16'(i);
      exp_out[i] = chain[16*i +: 16];
    end
    start_op();
    load_words(1);
    check("gap_test_low2", gap_hi, 0);
    finish_op(-1, 0);

`ifndef SCAN_CAPTURE_EN
    check("outvalid_never", ov_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_controller.md
# scan_controller

Scan-chain host for the datapath's serial test port. It collects a full chain image from a 16-bit word interface and drives `Test`/`SDI` for one unbroken shift burst. It captures the bits returned on `SDO` and hands them back as 16-bit words. It sits between the chip-level debug/test access logic and the datapath scan pins.

## Interface
- `CHAIN_LEN`, 128: scan chain length in bits; must be a non-zero multiple of 16. `WORDS = CHAIN_LEN/16`.
- `Clock  input  1  system clock; all state changes on the rising edge`
- `Reset  input  1  asynchronous, active-high reset`
- `Start  input  1  request a scan operation; sampled only in IDLE`
- `Busy  output  1  high whenever state != IDLE`
- `Done  output  1  one-cycle pulse at the end of an operation`
- `InData  input  16  chain image word, valid/ready handshake`
- `InValid  input  1  InData valid`
- `InReady  output  1  controller accepts InData`
- `OutData  output  16  captured chain word`
- `OutValid  output  1  OutData valid`
- `OutReady  input  1  consumer accepts OutData`
- `Test  output  1  scan enable to the datapath`
- `SDI  output  1  serial data into the chain`
- `SDO  input  1  serial data from the chain tail`

## Operation
- Internal `buf[CHAIN_LEN-1:0]`, word counter (0..WORDS), bit counter (0..CHAIN_LEN-1). FSM states: IDLE, LOAD, SHIFT, UNLOAD, FIN.
- IDLE: `Start`=1 moves to LOAD and clears the counters. `Start` in any other state is ignored.
- LOAD:
  - `InReady`=1.
  - On each `InValid&InReady`: `buf <= {InData, buf[CHAIN_LEN-1:16]}` and the word counter increments.
  - After the WORDS-th transfer, go to SHIFT. Word 0 then sits in `buf[15:0]`.
- SHIFT:
  - `Test`=1 for exactly CHAIN_LEN consecutive cycles; no stall is possible.
  - Each cycle `SDI = buf[0]`.
  - Each edge: `buf <= {SDO, buf[CHAIN_LEN-1:1]}`, with `SDO` sampled at that same edge.
  - After CHAIN_LEN edges go to UNLOAD. The bit shifted in first is the first bit returned on the next operation, so the ordering of in and out words matches.
- UNLOAD:
  - `OutValid`=1 and `OutData = buf[15:0]`.
  - On each `OutValid&OutReady`: `buf >>= 16` and the word counter increments.
  - After WORDS transfers, go to FIN.
- FIN: `Done`=1 for one cycle, then IDLE.
- `OutData` must stay stable while `OutValid&!OutReady`.
- `Test` is low in every state except SHIFT, including during LOAD gaps and UNLOAD backpressure.

## Timing
- Reset values:
  - `Busy`, `Done`, `InReady`, `OutValid`, `Test`, `SDI` = 0; `OutData` = 0.
  - State IDLE, counters 0.
  - `buf` contents are don't-care.
- Reset mid-operation: `Test` and `SDI` drop to 0 asynchronously and the operation is abandoned. The next `Start` after deassertion behaves normally.
- `Test`, `SDI` and all handshake outputs are driven directly from flops; none of them is combinational from inputs.
- Start in IDLE at edge t: `Busy`=1 and `InReady`=1 from cycle t+1.
- Last LOAD handshake at edge t: `Test`=1 in cycles t+1 .. t+CHAIN_LEN.
- `OutValid`=1 from cycle t+CHAIN_LEN+1.
- Last UNLOAD handshake at edge u: `Done`=1 and `Busy`=1 in cycle u+1; IDLE from u+2.
- Minimum operation with zero-wait handshakes: 2 + WORDS + CHAIN_LEN + WORDS + 1 cycles.

## Configuration
- `SCAN_CAPTURE_EN` defined: full behaviour above, with SDO capture and the UNLOAD phase.
- `SCAN_CAPTURE_EN` undefined:
  - `SDO` is ignored and `buf` shifts in 0.
  - UNLOAD is removed; SHIFT goes directly to FIN.
  - `OutValid` and `OutData` are tied to 0.
  - `Done` pulses in the cycle after the last shift edge.

## Test plan
- Bench uses CHAIN_LEN=128 with a 128-bit scan model of the chain.
- Reset then idle: all outputs 0, `Test`=0 for 50 cycles with `Start` low, `Busy`=0.
- Chain preloaded with 0xA5A5 ×8, load words 0x0001..0x0008: `Test` high for exactly 128 cycles, `OutData` sequence 0xA5A5 ×8, chain model then holds 0x0001..0x0008, one `Done` pulse.
- Second operation loading 0x0000 ×8: `OutData` sequence 0x0001..0x0008 (round-trip ordering).
- `InValid` gaps of 3 cycles between words and `OutReady` low for 5 cycles on word 2: `Test` stays 0 during the gaps, `OutData` stays 0x0003 while stalled, total `Test` high count is 128.
- `Start` pulsed during SHIFT is ignored; `Reset` asserted at shift cycle 40 drops `Test`/`Busy` to 0 immediately, and a following full operation completes correctly.
- `SCAN_CAPTURE_EN` undefined: `OutValid` is never 1, and `Done` is 1 exactly one cycle after the 128th shift cycle.
